core_savestate_ctrl: RTL and testbench

//  Downstream consumer of the bridge command handler's savestate handshake (savestate_start/_load -> ack/busy/ok/err).
//  On a save request: halts the core, streams WORDS 32-bit state words from the core into the bridge-visible savestate buffer RAM.
//  On a load request: halts the core and streams the buffer back into the core.
//  The halt is released when the transfer completes.

---
 rtl/core_savestate_pkg.sv | 25 ++
 rtl/core_savestate_ctrl_watchdog.sv | 29 ++
 rtl/core_savestate_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_core_savestate_ctrl.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_savestate_pkg.sv
// Shared types and defaults for the savestate controller: FSM states, transfer direction
// and the default transfer size and stall limit.
package core_savestate_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HALT,
    SAVE_RQ,
    SAVE_WT,
    LOAD_RA,
    LOAD_RD,
    LOAD_WR,
    FIN
  } state_t;

  typedef enum logic {
    SAVE,
    LOAD
  } dir_t;

  localparam int unsigned DEF_WORDS   = 256;
  localparam int unsigned DEF_AW      = 10;
  localparam int unsigned DEF_TIMEOUT = 1048576;

endpackage

// File: rtl/core_savestate_ctrl_watchdog.sv
// Stall counter for the savestate controller: counts run cycles since the last clear and
// flags expiry on the LIMIT-th consecutive run cycle (used only with SAVESTATE_TIMEOUT_EN).
module savestate_watchdog #(
  parameter int unsigned LIMIT = 1048576
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_run,
  output logic o_expired
);

  localparam int unsigned CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_run) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_expired = i_run && !i_clear && (r_cnt == CW'(LIMIT - 1));

endmodule

// File: rtl/core_savestate_ctrl.sv
// Savestate controller: halts the core and streams WORDS state words core->buffer (save)
// or buffer->core (load). Optional stall abort enabled by defining SAVESTATE_TIMEOUT_EN.
module core_savestate_ctrl
  import core_savestate_pkg::*;
#(
  parameter int unsigned WORDS   = DEF_WORDS,
  parameter int unsigned AW      = DEF_AW,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          savestate_start,
  input  logic          savestate_load,
  output logic          ss_start_ack,
  output logic          ss_start_busy,
  output logic          ss_start_ok,
  output logic          ss_start_err,
  output logic          ss_load_ack,
  output logic          ss_load_busy,
  output logic          ss_load_ok,
  output logic          ss_load_err,
  output logic          halt_req,
  input  logic          halt_ack,
  output logic          st_rd,
  input  logic          st_rd_valid,
  input  logic [31:0]   st_rd_data,
  output logic          st_wr_valid,
  input  logic          st_wr_ready,
  output logic [31:0]   st_wr_data,
  output logic [AW-1:0] buf_addr,
  output logic          buf_we,
  output logic [31:0]   buf_wdata,
  input  logic [31:0]   buf_rdata
);

  if (WORDS < 1 || (64'd1 << AW) < 64'(WORDS) || TIMEOUT < 1) begin : g_bad_cfg
    $error("core_savestate_ctrl: invalid WORDS/AW/TIMEOUT");
  end

  state_t        r_state;
  dir_t          r_dir;
  logic [AW-1:0] r_cnt;
  logic          r_prev_start, r_prev_load;
  logic          r_start_ack, r_start_busy, r_start_ok;
  logic          r_load_ack, r_load_busy, r_load_ok;
  logic          r_halt_req, r_st_rd, r_st_wr_valid, r_buf_we;
  logic [31:0]   r_st_wr_data, r_buf_wdata;
  logic [AW-1:0] r_buf_addr;

  logic w_start_edge, w_load_edge, w_last;
  assign w_start_edge = savestate_start & ~r_prev_start;
  assign w_load_edge  = savestate_load & ~r_prev_load;
  assign w_last       = (r_cnt == AW'(WORDS - 1));

`ifdef SAVESTATE_TIMEOUT_EN
  logic r_start_err, r_load_err;
  logic w_run, w_accept, w_expired;
  assign w_run    = (r_state == HALT) || (r_state == SAVE_WT) || (r_state == LOAD_WR);
  assign w_accept = ((r_state == SAVE_WT) && st_rd_valid) || ((r_state == LOAD_WR) && st_wr_ready);

  savestate_watchdog #(.LIMIT(TIMEOUT)) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (!w_run || w_accept),
    .i_run    (w_run),
    .o_expired(w_expired)
  );

  assign ss_start_err = r_start_err;
  assign ss_load_err  = r_load_err;
`else
  assign ss_start_err = 1'b0;
  assign ss_load_err  = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_dir         <= SAVE;
      r_cnt         <= '0;
      r_prev_start  <= 1'b0;
      r_prev_load   <= 1'b0;
      r_start_ack   <= 1'b0;
      r_start_busy  <= 1'b0;
      r_start_ok    <= 1'b0;
      r_load_ack    <= 1'b0;
      r_load_busy   <= 1'b0;
      r_load_ok     <= 1'b0;
      r_halt_req    <= 1'b0;
      r_st_rd       <= 1'b0;
      r_st_wr_valid <= 1'b0;
      r_st_wr_data  <= '0;
      r_buf_addr    <= '0;
      r_buf_we      <= 1'b0;
      r_buf_wdata   <= '0;
`ifdef SAVESTATE_TIMEOUT_EN
      r_start_err   <= 1'b0;
      r_load_err    <= 1'b0;
`endif
    end else begin
      r_prev_start <= savestate_start;
      r_prev_load  <= savestate_load;
      r_start_ack  <= 1'b0;
      r_load_ack   <= 1'b0;
      r_st_rd      <= 1'b0;
      r_buf_we     <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_start_edge) begin
            r_dir        <= SAVE;
            r_start_ack  <= 1'b1;
            r_start_ok   <= 1'b0;
            r_start_busy <= 1'b1;
            r_halt_req   <= 1'b1;
            r_cnt        <= '0;
            r_state      <= HALT;
`ifdef SAVESTATE_TIMEOUT_EN
            r_start_err  <= 1'b0;
`endif
          end else if (w_load_edge) begin
            r_dir       <= LOAD;
            r_load_ack  <= 1'b1;
            r_load_ok   <= 1'b0;
            r_load_busy <= 1'b1;
            r_halt_req  <= 1'b1;
            r_cnt       <= '0;
            r_state     <= HALT;
`ifdef SAVESTATE_TIMEOUT_EN
            r_load_err  <= 1'b0;
`endif
          end
        end
        // The buffer address is registered on entry to LOAD_RA so the RAM samples it
        // at the end of LOAD_RA and its data is valid during LOAD_RD.
        HALT: begin
          if (halt_ack) begin
            if (r_dir == SAVE) begin
              r_state <= SAVE_RQ;
            end else begin
              r_buf_addr <= r_cnt;
              r_state    <= LOAD_RA;
            end
          end
        end
        SAVE_RQ: begin
          r_st_rd <= 1'b1;
          r_state <= SAVE_WT;
        end
        SAVE_WT: begin
          if (st_rd_valid) begin
            r_buf_we    <= 1'b1;
            r_buf_addr  <= r_cnt;
            r_buf_wdata <= st_rd_data;
            if (w_last) begin
              r_state <= FIN;
            end else begin
              r_cnt   <= r_cnt + AW'(1);
              r_state <= SAVE_RQ;
            end
          end
        end
        LOAD_RA: r_state <= LOAD_RD;
        LOAD_RD: begin
          r_st_wr_data  <= buf_rdata;
          r_st_wr_valid <= 1'b1;
          r_state       <= LOAD_WR;
        end
        LOAD_WR: begin
          if (st_wr_ready) begin
            r_st_wr_valid <= 1'b0;
            if (w_last) begin
              r_state <= FIN;
            end else begin
              r_cnt      <= r_cnt + AW'(1);
              r_buf_addr <= r_cnt + AW'(1);
              r_state    <= LOAD_RA;
            end
          end
        end
        FIN: begin
          r_halt_req   <= 1'b0;
          r_start_busy <= 1'b0;
          r_load_busy  <= 1'b0;
          if (r_dir == SAVE) r_start_ok <= 1'b1;
          else               r_load_ok  <= 1'b1;
          r_state <= IDLE;
        end
      endcase
`ifdef SAVESTATE_TIMEOUT_EN
      if (w_expired) begin
        r_halt_req    <= 1'b0;
        r_start_busy  <= 1'b0;
        r_load_busy   <= 1'b0;
        r_st_wr_valid <= 1'b0;
        if (r_dir == SAVE) r_start_err <= 1'b1;
        else               r_load_err  <= 1'b1;
        r_state <= IDLE;
      end
`endif
    end
  end

  assign ss_start_ack  = r_start_ack;
  assign ss_start_busy = r_start_busy;
  assign ss_start_ok   = r_start_ok;
  assign ss_load_ack   = r_load_ack;
  assign ss_load_busy  = r_load_busy;
  assign ss_load_ok    = r_load_ok;
  assign halt_req      = r_halt_req;
  assign st_rd         = r_st_rd;
  assign st_wr_valid   = r_st_wr_valid;
  assign st_wr_data    = r_st_wr_data;
  assign buf_addr      = r_buf_addr;
  assign buf_we        = r_buf_we;
  assign buf_wdata     = r_buf_wdata;

endmodule

// File: tb/tb_core_savestate_ctrl.sv
// Directed bench for core_savestate_ctrl (WORDS=4, TIMEOUT=16) with a 1-cycle-latency
// buffer RAM model; the stall-abort scenario adapts to SAVESTATE_TIMEOUT_EN.
module tb_core_savestate_ctrl;

  localparam int unsigned WORDS = 4;
  localparam int unsigned AW    = 4;

  logic          clk, rst;
  logic          savestate_start, savestate_load;
  logic          ss_start_ack, ss_start_busy, ss_start_ok, ss_start_err;
  logic          ss_load_ack, ss_load_busy, ss_load_ok, ss_load_err;
  logic          halt_req, halt_ack;
  logic          st_rd, st_rd_valid;
  logic [31:0]   st_rd_data;
  logic          st_wr_valid, st_wr_ready;
  logic [31:0]   st_wr_data;
  logic [AW-1:0] buf_addr;
  logic          buf_we;
  logic [31:0]   buf_wdata, buf_rdata;

  int checks = 0;
  int failures = 0;

  core_savestate_ctrl #(.WORDS(WORDS), .AW(AW), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .savestate_start(savestate_start), .savestate_load(savestate_load),
    .ss_start_ack(ss_start_ack), .ss_start_busy(ss_start_busy),
    .ss_start_ok(ss_start_ok), .ss_start_err(ss_start_err),
    .ss_load_ack(ss_load_ack), .ss_load_busy(ss_load_busy),
    .ss_load_ok(ss_load_ok), .ss_load_err(ss_load_err),
    .halt_req(halt_req), .halt_ack(halt_ack),
    .st_rd(st_rd), .st_rd_valid(st_rd_valid), .st_rd_data(st_rd_data),
    .st_wr_valid(st_wr_valid), .st_wr_ready(st_wr_ready), .st_wr_data(st_wr_data),
    .buf_addr(buf_addr), .buf_we(buf_we), .buf_wdata(buf_wdata), .buf_rdata(buf_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Buffer RAM: bench preload port has priority over the DUT write port.
  logic [31:0]   mem [16];
  logic          tb_we;
  logic [AW-1:0] tb_addr;
  logic [31:0]   tb_wdata;
  always @(posedge clk) begin
    if (tb_we)       mem[tb_addr] <= tb_wdata;
    else if (buf_we) mem[buf_addr] <= buf_wdata;
    buf_rdata <= mem[buf_addr];
  end

  logic [79:0] outs;
  assign outs = {ss_start_ack, ss_start_busy, ss_start_ok, ss_start_err,
                 ss_load_ack, ss_load_busy, ss_load_ok, ss_load_err,
                 halt_req, st_rd, st_wr_valid, st_wr_data, buf_addr, buf_we, buf_wdata};

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    checks++;
    if (outs !== '0) begin
      failures++;
      $display("FAIL reset_async outs=%h exp=0", outs);
    end
    repeat (2) tick;
    rst = 1'b0;
    repeat (2) tick;
    checks++;
    if (outs !== '0) begin
      failures++;
      $display("FAIL reset_idle outs=%h exp=0", outs);
    end
  endtask

  task automatic test_save;
    logic [31:0] a [4];
    int unsigned widx, ridx, acks;
    logic pend, done;
    for (int i = 0; i < 4; i++) a[i] = 32'hA0A0_0000 + 32'(i);
    widx = 0; ridx = 0; acks = 0; pend = 1'b0; done = 1'b0;
    savestate_start = 1'b1;
    tick;
    checks++;
    if (ss_start_ack !== 1'b1 || ss_start_busy !== 1'b1 || halt_req !== 1'b1 || ss_load_ack !== 1'b0) begin
      failures++;
      $display("FAIL save_ack ack=%b busy=%b halt=%b lack=%b exp 1 1 1 0",
               ss_start_ack, ss_start_busy, halt_req, ss_load_ack);
    end
    tick;
    checks++;
    if (ss_start_ack !== 1'b0 || ss_start_busy !== 1'b1) begin
      failures++;
      $display("FAIL save_ack_pulse ack=%b busy=%b exp 0 1", ss_start_ack, ss_start_busy);
    end
    tick; tick;
    halt_ack = 1'b1;
    for (int c = 0; c < 60 && !done; c++) begin
      tick;
      if (buf_we) begin
        checks++;
        if (widx >= 4 || buf_addr !== 4'(widx) || buf_wdata !== a[widx]) begin
          failures++;
          $display("FAIL save_write idx=%0d addr=%0d data=%h exp addr=%0d data=%h",
                   widx, buf_addr, buf_wdata, widx, (widx < 4) ? a[widx] : 32'h0);
        end
        widx++;
      end
      if (ss_start_ack || ss_load_ack) acks++;
      st_rd_valid = pend;
      st_rd_data  = pend ? a[ridx] : 32'hDEAD_BEEF;
      if (pend) ridx++;
      pend = st_rd;
      if (ss_start_ok) done = 1'b1;
    end
    st_rd_valid = 1'b0;
    checks++;
    if (done !== 1'b1 || widx != 4 || acks != 0) begin
      failures++;
      $display("FAIL save_done ok=%b writes=%0d extra_acks=%0d exp 1 4 0", done, widx, acks);
    end
    checks++;
    if (halt_req !== 1'b0 || ss_start_busy !== 1'b0 || ss_start_err !== 1'b0) begin
      failures++;
      $display("FAIL save_release halt=%b busy=%b err=%b exp 0 0 0", halt_req, ss_start_busy, ss_start_err);
    end
    savestate_start = 1'b0;
    halt_ack = 1'b0;
    tick;
  endtask

  task automatic test_load;
    logic [31:0] b [4];
    int unsigned widx;
    logic done;
    for (int i = 0; i < 4; i++) b[i] = 32'hB0B0_0000 + 32'(i);
    widx = 0; done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tb_we = 1'b1; tb_addr = 4'(i); tb_wdata = b[i];
      tick;
    end
    tb_we = 1'b0;
    savestate_load = 1'b1;
    halt_ack = 1'b1;
    tick;
    checks++;
    if (ss_load_ack !== 1'b1 || ss_load_busy !== 1'b1 || ss_start_ack !== 1'b0) begin
      failures++;
      $display("FAIL load_ack ack=%b busy=%b sack=%b exp 1 1 0", ss_load_ack, ss_load_busy, ss_start_ack);
    end
    for (int c = 0; c < 80 && !done; c++) begin
      if (st_wr_valid) begin
        checks++;
        if (widx >= 4 || st_wr_data !== b[widx]) begin
          failures++;
          $display("FAIL load_data idx=%0d data=%h exp %h", widx, st_wr_data, (widx < 4) ? b[widx] : 32'h0);
        end
      end
      st_wr_ready = c[0];
      if (st_wr_valid && st_wr_ready) widx++;
      tick;
      if (ss_load_ok) done = 1'b1;
    end
    st_wr_ready = 1'b0;
    checks++;
    if (done !== 1'b1 || widx != 4 || halt_req !== 1'b0 || ss_load_busy !== 1'b0) begin
      failures++;
      $display("FAIL load_done ok=%b words=%0d halt=%b busy=%b exp 1 4 0 0", done, widx, halt_req, ss_load_busy);
    end
    checks++;
    if (ss_start_ok !== 1'b1) begin
      failures++;
      $display("FAIL save_ok_sticky ok=%b exp 1", ss_start_ok);
    end
    savestate_load = 1'b0;
    halt_ack = 1'b0;
    tick;
  endtask

  task automatic test_collision;
    int unsigned widx, sacks, lacks;
    logic pend, done;
    widx = 0; sacks = 0; lacks = 0; pend = 1'b0; done = 1'b0;
    savestate_start = 1'b1;
    savestate_load  = 1'b1;
    halt_ack = 1'b1;
    tick;
    checks++;
    if (ss_start_ack !== 1'b1 || ss_load_ack !== 1'b0 || ss_load_busy !== 1'b0) begin
      failures++;
      $display("FAIL both_edges sack=%b lack=%b lbusy=%b exp 1 0 0", ss_start_ack, ss_load_ack, ss_load_busy);
    end
    for (int c = 0; c < 60 && !done; c++) begin
      tick;
      if (c == 5) savestate_start = 1'b0;
      if (c == 6) savestate_start = 1'b1;
      if (buf_we) widx++;
      if (ss_start_ack) sacks++;
      if (ss_load_ack) lacks++;
      st_rd_valid = pend;
      st_rd_data  = 32'hC0DE_0000;
      pend = st_rd;
      if (ss_start_ok) done = 1'b1;
    end
    st_rd_valid = 1'b0;
    repeat (3) begin
      tick;
      if (ss_start_ack) sacks++;
      if (ss_load_ack) lacks++;
    end
    checks++;
    if (done !== 1'b1 || widx != 4 || sacks != 0 || lacks != 0) begin
      failures++;
      $display("FAIL busy_edges ok=%b writes=%0d sacks=%0d lacks=%0d exp 1 4 0 0", done, widx, sacks, lacks);
    end
    checks++;
    if (ss_load_ok !== 1'b1 || ss_start_busy !== 1'b0 || halt_req !== 1'b0) begin
      failures++;
      $display("FAIL load_ok_kept lok=%b busy=%b halt=%b exp 1 0 0", ss_load_ok, ss_start_busy, halt_req);
    end
    savestate_start = 1'b0;
    savestate_load  = 1'b0;
    halt_ack = 1'b0;
    tick;
  endtask

  task automatic test_reset_mid_save;
    logic [31:0] d [4];
    int unsigned widx, ridx;
    logic pend, done;
    for (int i = 0; i < 4; i++) d[i] = 32'hC0C0_0000 + 32'(i);
    widx = 0; ridx = 0; pend = 1'b0; done = 1'b0;
    savestate_start = 1'b1;
    halt_ack = 1'b1;
    for (int c = 0; c < 40 && widx < 2; c++) begin
      tick;
      if (buf_we) widx++;
      st_rd_valid = pend;
      st_rd_data  = 32'h1111_1111;
      pend = st_rd;
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (widx != 2 || outs !== '0) begin
      failures++;
      $display("FAIL reset_mid_save writes=%0d outs=%h exp 2 0", widx, outs);
    end
    tick;
    savestate_start = 1'b0;
    st_rd_valid = 1'b0;
    pend = 1'b0;
    tick;
    rst = 1'b0;
    tick;
    widx = 0;
    savestate_start = 1'b1;
    for (int c = 0; c < 60 && !done; c++) begin
      tick;
      if (buf_we) begin
        checks++;
        if (widx >= 4 || buf_addr !== 4'(widx) || buf_wdata !== d[widx]) begin
          failures++;
          $display("FAIL rerun_write idx=%0d addr=%0d data=%h exp addr=%0d data=%h",
                   widx, buf_addr, buf_wdata, widx, (widx < 4) ? d[widx] : 32'h0);
        end
        widx++;
      end
      st_rd_valid = pend;
      st_rd_data  = pend ? d[ridx] : 32'hDEAD_BEEF;
      if (pend) ridx++;
      pend = st_rd;
      if (ss_start_ok) done = 1'b1;
    end
    st_rd_valid = 1'b0;
    checks++;
    if (done !== 1'b1 || widx != 4 || halt_req !== 1'b0) begin
      failures++;
      $display("FAIL rerun_done ok=%b writes=%0d halt=%b exp 1 4 0", done, widx, halt_req);
    end
    savestate_start = 1'b0;
    halt_ack = 1'b0;
    tick;
  endtask

  task automatic test_stall;
    halt_ack = 1'b0;
    savestate_start = 1'b1;
    tick;
    checks++;
    if (ss_start_ack !== 1'b1 || ss_start_ok !== 1'b0) begin
      failures++;
      $display("FAIL stall_ack ack=%b ok=%b exp 1 0", ss_start_ack, ss_start_ok);
    end
    repeat (15) tick;
    checks++;
    if (ss_start_err !== 1'b0 || ss_start_busy !== 1'b1 || halt_req !== 1'b1) begin
      failures++;
      $display("FAIL stall_before err=%b busy=%b halt=%b exp 0 1 1", ss_start_err, ss_start_busy, halt_req);
    end
    tick;
`ifdef SAVESTATE_TIMEOUT_EN
    checks++;
    if (ss_start_err !== 1'b1 || ss_start_busy !== 1'b0 || halt_req !== 1'b0 || ss_start_ok !== 1'b0) begin
      failures++;
      $display("FAIL timeout_abort err=%b busy=%b halt=%b ok=%b exp 1 0 0 0",
               ss_start_err, ss_start_busy, halt_req, ss_start_ok);
    end
    savestate_start = 1'b0;
    tick;
    savestate_start = 1'b1;
    tick;
    checks++;
    if (ss_start_ack !== 1'b1 || ss_start_err !== 1'b0 || ss_start_busy !== 1'b1) begin
      failures++;
      $display("FAIL err_clear ack=%b err=%b busy=%b exp 1 0 1", ss_start_ack, ss_start_err, ss_start_busy);
    end
`else
    repeat (20) tick;
    checks++;
    if (ss_start_err !== 1'b0 || ss_start_busy !== 1'b1 || halt_req !== 1'b1) begin
      failures++;
      $display("FAIL stall_wait err=%b busy=%b halt=%b exp 0 1 1", ss_start_err, ss_start_busy, halt_req);
    end
`endif
    rst = 1'b1;
    savestate_start = 1'b0;
    tick;
    rst = 1'b0;
    tick;
  endtask

  initial begin
    savestate_start = 1'b0; savestate_load = 1'b0;
    halt_ack = 1'b0; st_rd_valid = 1'b0; st_rd_data = '0; st_wr_ready = 1'b0;
    tb_we = 1'b0; tb_addr = '0; tb_wdata = '0;
    test_reset;
    test_save;
    test_load;
    test_collision;
    test_reset_mid_save;
    test_stall;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
